pe_ofmap_writeback: RTL and testbench

- Downstream stage of the PE group. Consumes the accumulated output stream (O_DataOut / O_DataOutValid / O_DataOutRdy) and buffers it in a small FIFO.
- Optionally applies ReLU, then writes each result to the output-feature-map SRAM at sequential addresses from a configured base.
- A start/done job interface is driven by the top-level controller. One job = a fixed number of output words.

---
 rtl/pe_ofmap_writeback.sv | 184 ++++++++++++++++++
 tb/tb_pe_ofmap_writeback.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_ofmap_writeback.sv
// Output-feature-map writeback stage.
// Buffers the accumulated PE output stream in a small show-ahead FIFO. It can
// clamp negative words to zero (ReLU) as they are pushed. It then writes
// each word to the ofmap SRAM at sequential addresses starting from a base.
// The top-level controller runs jobs through a Start/Done interface.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   Start, NumOutputs,  job start pulse and configuration, latched in IDLE
//   BaseAddr, ReluEn
//   DataIn*             input stream from the PE group (valid/ready)
//   Mem_Wr*             SRAM write port (request/ready)
//   Busy, Done, WrCount job status
module pe_ofmap_writeback #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned FifoDepth     = 4,
  parameter int unsigned FifoAddrWidth = 2,
  parameter int unsigned AddrWidth     = 10,
  parameter int unsigned CountWidth    = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [CountWidth-1:0] NumOutputs,
  input  logic [AddrWidth-1:0]  BaseAddr,
  input  logic                  ReluEn,
  input  logic                  DataInValid,
  output logic                  DataInRdy,
  input  logic [DataWidth-1:0]  DataIn,
  output logic                  Mem_WrEn,
  input  logic                  Mem_WrRdy,
  output logic [AddrWidth-1:0]  Mem_WrAddr,
  output logic [DataWidth-1:0]  Mem_WrData,
  output logic                  Busy,
  output logic                  Done,
  output logic [CountWidth-1:0] WrCount
);

  localparam int unsigned OccWidth = FifoAddrWidth + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [CountWidth-1:0]    num_q, num_d;
  logic [AddrWidth-1:0]     base_q, base_d;
  logic                     relu_q, relu_d;
  logic [CountWidth-1:0]    recv_q, recv_d;
  logic [CountWidth-1:0]    wr_cnt_q, wr_cnt_d;
  logic [OccWidth-1:0]      occ_q, occ_d;
  logic [FifoAddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [FifoAddrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [DataWidth-1:0]     mem_q [FifoDepth];
  logic [DataWidth-1:0]     mem_d [FifoDepth];

  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     in_rdy;
  logic                     push;
  logic                     pop;
  logic [DataWidth-1:0]     push_data;

  // Handshake terms depend only on flops, so there is no input-to-ready path.
  always_comb begin
    fifo_full  = (occ_q == OccWidth'(FifoDepth));
    fifo_empty = (occ_q == '0);
    in_rdy     = (state_q == S_RUN) && !fifo_full && (recv_q < num_q);
    push       = DataInValid && in_rdy;
    pop        = !fifo_empty && Mem_WrRdy;
    // ReLU on the sign bit only; positive values pass through unchanged.
    push_data  = (relu_q && DataIn[DataWidth-1]) ? '0 : DataIn;
  end

  // Next-state logic for the job FSM, counters and FIFO.
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    base_d   = base_q;
    relu_d   = relu_q;
    recv_d   = recv_q;
    wr_cnt_d = wr_cnt_q;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;

    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      recv_d          = recv_q + CountWidth'(1);
      wr_ptr_d        = (wr_ptr_q == FifoAddrWidth'(FifoDepth - 1)) ? '0
                                                                    : wr_ptr_q + FifoAddrWidth'(1);
    end

    if (pop) begin
      wr_cnt_d = wr_cnt_q + CountWidth'(1);
      rd_ptr_d = (rd_ptr_q == FifoAddrWidth'(FifoDepth - 1)) ? '0
                                                             : rd_ptr_q + FifoAddrWidth'(1);
    end

    // A pop at full frees a slot, but ready was already low, so occupancy
    // only ever moves by one.
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OccWidth'(1);
      2'b01:   occ_d = occ_q - OccWidth'(1);
      default: occ_d = occ_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          num_d    = NumOutputs;
          base_d   = BaseAddr;
          relu_d   = ReluEn;
          recv_d   = '0;
          wr_cnt_d = '0;
          state_d  = (NumOutputs == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (recv_d == num_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // All words are received, so matching write count implies an empty FIFO.
        if (wr_cnt_q == num_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      num_q    <= '0;
      base_q   <= '0;
      relu_q   <= 1'b0;
      recv_q   <= '0;
      wr_cnt_q <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      base_q   <= base_d;
      relu_q   <= relu_d;
      recv_q   <= recv_d;
      wr_cnt_q <= wr_cnt_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  // Outputs are decoded from flops only; the FIFO head is shown ahead and
  // holds until popped.
  always_comb begin
    DataInRdy  = in_rdy;
    Mem_WrEn   = !fifo_empty;
    Mem_WrData = mem_q[rd_ptr_q];
    // The address wraps modulo the SRAM size.
    Mem_WrAddr = base_q + wr_cnt_q[AddrWidth-1:0];
    Busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    Done       = (state_q == S_DONE);
    WrCount    = wr_cnt_q;
  end

endmodule

// File: tb/tb_pe_ofmap_writeback.sv
module tb_pe_ofmap_writeback;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          Start;
  logic [CW-1:0] NumOutputs;
  logic [AW-1:0] BaseAddr;
  logic          ReluEn;
  logic          DataInValid;
  logic          DataInRdy;
  logic [DW-1:0] DataIn;
  logic          Mem_WrEn;
  logic          Mem_WrRdy;
  logic [AW-1:0] Mem_WrAddr;
  logic [DW-1:0] Mem_WrData;
  logic          Busy;
  logic          Done;
  logic [CW-1:0] WrCount;

  pe_ofmap_writeback dut (
    .clk(clk), .rst(rst), .Start(Start), .NumOutputs(NumOutputs), .BaseAddr(BaseAddr),
    .ReluEn(ReluEn), .DataInValid(DataInValid), .DataInRdy(DataInRdy), .DataIn(DataIn),
    .Mem_WrEn(Mem_WrEn), .Mem_WrRdy(Mem_WrRdy), .Mem_WrAddr(Mem_WrAddr),
    .Mem_WrData(Mem_WrData), .Busy(Busy), .Done(Done), .WrCount(WrCount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference rules: ReLU clamps negatives, addresses wrap modulo 1024.
  function automatic logic [DW-1:0] ref_data(input bit en, input logic [DW-1:0] d);
    return (en && $signed(d) < 0) ? 32'd0 : d;
  endfunction

  function automatic logic [AW-1:0] ref_addr(input int base, input int i);
    return AW'((base + i) % 1024);
  endfunction

  // Per-job observations.
  logic [DW-1:0] stream [$];
  logic [AW-1:0] got_addr [64];
  logic [DW-1:0] got_data [64];
  int n_acc, n_wr, n_done, done_cyc, first_acc, first_wr, max_occ, stall_err, acc_at9;
  bit rdy_seen, rdy_at9, busy_at0;

  task automatic pad_stream(input int total);
    while (stream.size() < total) stream.push_back($urandom);
  endtask

  // rdy_mode: 0 always ready, 1 random, 2 stalled for the first 10 cycles.
  task automatic run_job(input int num, input int base, input bit relu, input int rdy_mode,
                         input bit rnd_valid, input bit poke_start);
    int idx = 0;
    int tail = -1;
    bit prev_stall = 0;
    bit acc;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    n_acc = 0; n_wr = 0; n_done = 0; done_cyc = -1; first_acc = -1; first_wr = -1;
    max_occ = 0; stall_err = 0; acc_at9 = -1; rdy_seen = 0; rdy_at9 = 0; busy_at0 = 0;
    for (int i = 0; i < 64; i++) begin
      got_addr[i] = 'x;
      got_data[i] = 'x;
    end
    pad_stream(num + 8);
    Start = 1; NumOutputs = CW'(num); BaseAddr = AW'(base); ReluEn = relu;
    DataInValid = 0; Mem_WrRdy = 1;
    @(posedge clk); #1;
    // Scramble cfg inputs so only the latched copy can be in use.
    Start = 0; NumOutputs = 11'h7ff; BaseAddr = 10'h155; ReluEn = ~relu;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      DataInValid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      DataIn      = stream[idx];
      case (rdy_mode)
        0:       Mem_WrRdy = 1'b1;
        1:       Mem_WrRdy = ($urandom_range(0, 3) != 0);
        default: Mem_WrRdy = (cyc >= 10);
      endcase
      Start = poke_start && (cyc == 2);
      #1;
      if (prev_stall && (Mem_WrEn !== 1'b1 || Mem_WrAddr !== pa || Mem_WrData !== pd))
        stall_err++;
      if (n_acc - n_wr > max_occ) max_occ = n_acc - n_wr;
      if (cyc == 0) busy_at0 = Busy;
      if (cyc == 9) begin
        acc_at9 = n_acc;
        rdy_at9 = DataInRdy;
      end
      if (DataInRdy === 1'b1) rdy_seen = 1;
      acc = DataInValid && DataInRdy;
      if (acc) begin
        if (n_acc == 0) first_acc = cyc;
        n_acc++;
      end
      if (Mem_WrEn && Mem_WrRdy) begin
        if (n_wr == 0) first_wr = cyc;
        if (n_wr < 64) begin
          got_addr[n_wr] = Mem_WrAddr;
          got_data[n_wr] = Mem_WrData;
        end
        n_wr++;
      end
      if (Done === 1'b1) begin
        if (n_done == 0) begin
          done_cyc = cyc;
          tail = 3;
        end
        n_done++;
      end
      prev_stall = Mem_WrEn && !Mem_WrRdy;
      pa = Mem_WrAddr;
      pd = Mem_WrData;
      @(posedge clk); #1;
      if (acc) idx++;
      if (tail == 0) break;
      if (tail > 0) tail--;
    end
    DataInValid = 0; Start = 0; Mem_WrRdy = 1;
  endtask

  // Common end-of-job checks against the reference rules.
  task automatic check_job(input string tag, input int num, input int base, input bit relu);
    check({tag, "_accepts"}, 64'(n_acc), 64'(num));
    check({tag, "_writes"}, 64'(n_wr), 64'(num));
    check({tag, "_done_pulses"}, 64'(n_done), 64'd1);
    check({tag, "_wrcount"}, 64'(WrCount), 64'(num));
    check({tag, "_busy_idle"}, 64'(Busy), 64'd0);
    check({tag, "_max_occ_le4"}, 64'(max_occ <= 4), 64'd1);
    check({tag, "_stall_stable"}, 64'(stall_err), 64'd0);
    for (int i = 0; i < num && i < 64; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(ref_addr(base, i)));
      check($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(ref_data(relu, stream[i])));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"}, 64'(DataInRdy), 64'd0);
    check({tag, "_wren"}, 64'(Mem_WrEn), 64'd0);
    check({tag, "_addr"}, 64'(Mem_WrAddr), 64'd0);
    check({tag, "_data"}, 64'(Mem_WrData), 64'd0);
    check({tag, "_busy"}, 64'(Busy), 64'd0);
    check({tag, "_done"}, 64'(Done), 64'd0);
    check({tag, "_wrcount"}, 64'(WrCount), 64'd0);
  endtask

  typedef struct {
    int              num;
    int              base;
    bit              relu;
    logic [3:0][31:0] din;
    logic [3:0][9:0]  eaddr;
    logic [3:0][31:0] edata;
  } vec_t;

  vec_t vecs [4];

  initial begin
    // Directed jobs with hand-computed expectations (element 0 is the first word).
    vecs[0] = '{4, 'h010, 1'b0, {32'd0, 32'd7, 32'hFFFF_FFFD, 32'd5},
                {10'h013, 10'h012, 10'h011, 10'h010},
                {32'd0, 32'd7, 32'hFFFF_FFFD, 32'd5}};
    vecs[1] = '{4, 'h020, 1'b1, {32'hFFFF_FF9C, 32'd9, 32'h8000_0000, 32'hFFFF_FFFF},
                {10'h023, 10'h022, 10'h021, 10'h020},
                {32'd0, 32'd9, 32'd0, 32'd0}};
    vecs[2] = '{4, 'h3FE, 1'b0, {32'd4, 32'd3, 32'd2, 32'd1},
                {10'h001, 10'h000, 10'h3FF, 10'h3FE},
                {32'd4, 32'd3, 32'd2, 32'd1}};
    vecs[3] = '{4, 'h100, 1'b1, {32'h8000_0001, 32'd0, 32'd1, 32'h7FFF_FFFF},
                {10'h103, 10'h102, 10'h101, 10'h100},
                {32'd0, 32'd0, 32'd1, 32'h7FFF_FFFF}};

    rst = 1; Start = 0; NumOutputs = '0; BaseAddr = '0; ReluEn = 0;
    DataInValid = 0; DataIn = '0; Mem_WrRdy = 1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 0;
    @(posedge clk); #1;

    // Table-driven directed jobs.
    for (int v = 0; v < 4; v++) begin
      stream.delete();
      for (int i = 0; i < 4; i++) stream.push_back(vecs[v].din[i]);
      run_job(vecs[v].num, vecs[v].base, vecs[v].relu, 0, 0, 0);
      check($sformatf("vec%0d_writes", v), 64'(n_wr), 64'd4);
      check($sformatf("vec%0d_done_pulses", v), 64'(n_done), 64'd1);
      check($sformatf("vec%0d_wrcount", v), 64'(WrCount), 64'd4);
      check($sformatf("vec%0d_busy_at_start", v), 64'(busy_at0), 64'd1);
      check($sformatf("vec%0d_latency", v), 64'(first_wr - first_acc), 64'd1);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("vec%0d_addr%0d", v, i), 64'(got_addr[i]), 64'(vecs[v].eaddr[i]));
        check($sformatf("vec%0d_data%0d", v, i), 64'(got_data[i]), 64'(vecs[v].edata[i]));
      end
    end

    // Backpressure: SRAM stalled for 10 cycles, 8-word job, continuous valid.
    stream.delete();
    run_job(8, 'h040, 0, 2, 0, 0);
    check("bp_accepts_while_stalled", 64'(acc_at9), 64'd4);
    check("bp_rdy_while_stalled", 64'(rdy_at9), 64'd0);
    check("bp_max_occ", 64'(max_occ), 64'd4);
    check_job("bp", 8, 'h040, 0);

    // Zero-length job: Done the cycle after Start, no traffic.
    stream.delete();
    run_job(0, 'h200, 0, 0, 0, 0);
    check("zero_done_cyc", 64'(done_cyc), 64'd0);
    check("zero_done_pulses", 64'(n_done), 64'd1);
    check("zero_writes", 64'(n_wr), 64'd0);
    check("zero_rdy_seen", 64'(rdy_seen), 64'd0);
    check("zero_wrcount", 64'(WrCount), 64'd0);

    // Over-supply with a Start poked during RUN.
    stream.delete();
    run_job(3, 'h080, 1, 0, 0, 1);
    check_job("oversupply", 3, 'h080, 1);

    // Reset in the middle of a job after 2 accepts.
    Start = 1; NumOutputs = 11'd6; BaseAddr = 10'h0C0; ReluEn = 0;
    DataInValid = 0; Mem_WrRdy = 0;
    @(posedge clk); #1;
    Start = 0;
    DataInValid = 1; DataIn = 32'h1111; @(posedge clk); #1;
    DataIn = 32'h2222; @(posedge clk); #1;
    check("midrst_pre_busy", 64'(Busy), 64'd1);
    check("midrst_pre_wren", 64'(Mem_WrEn), 64'd1);
    DataInValid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0; Mem_WrRdy = 1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    check_all_zero("midrst_idle");
    stream.delete();
    run_job(2, 'h0C8, 0, 0, 0, 0);
    check_job("after_rst", 2, 'h0C8, 0);

    // Randomized jobs against the reference rules.
    for (int j = 0; j < 8; j++) begin
      int num;
      int base;
      bit relu;
      num  = $urandom_range(1, 20);
      base = $urandom_range(0, 1023);
      relu = 1'($urandom_range(0, 1));
      stream.delete();
      for (int i = 0; i < num + 8; i++)
        stream.push_back(($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 1000));
      run_job(num, base, relu, 1, 1, 0);
      check_job($sformatf("rnd%0d", j), num, base, relu);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
